// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: state encoding and default width.
package counter_seq_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_counter_core.sv
// WIDTH-bit up/down counter register with synchronous load and count enable.
module seq_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  // Load takes precedence over stepping; stepping wraps modulo 2^WIDTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (enable) begin
      count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run-control FSM that turns a loadable counter into a one-shot or periodic timer.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             dir_up,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  seq_state_t       state, state_next;
  logic [WIDTH-1:0] sh_load, sh_term;
  logic             sh_up, sh_periodic;
  logic             latch_cfg;
  logic             core_load, core_en;
  logic [WIDTH-1:0] core_din;
  logic             tc_next;

  seq_counter_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (core_load),
    .din    (core_din),
    .enable (core_en),
    .up     (sh_up),
    .count  (count)
  );

  // Decision order: stop, then start, then per-state hold/step behaviour.
  always_comb begin
    state_next = state;
    latch_cfg  = 1'b0;
    core_load  = 1'b0;
    core_din   = sh_load;
    core_en    = 1'b0;
    tc_next    = 1'b0;
    if (stop) begin
      state_next = ST_IDLE;
      core_load  = 1'b1;
      core_din   = '0;
    end else if (start) begin
      state_next = ST_RUN;
      latch_cfg  = 1'b1;
      core_load  = 1'b1;
      core_din   = load_val;
    end else begin
      case (state)
        ST_RUN: begin
          if (hold) begin
            state_next = ST_PAUSE;
          end else if (count == sh_term) begin
            tc_next = 1'b1;
            if (sh_periodic) core_load = 1'b1;
            else             state_next = ST_DONE;
          end else begin
            core_en = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!hold) state_next = ST_RUN;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      sh_load     <= '0;
      sh_term     <= '0;
      sh_up       <= 1'b0;
      sh_periodic <= 1'b0;
      tc          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_next;
      tc    <= tc_next;
      busy  <= (state_next == ST_RUN) || (state_next == ST_PAUSE);
      done  <= (state_next == ST_DONE);
      if (latch_cfg) begin
        sh_load     <= load_val;
        sh_term     <= term_val;
        sh_up       <= dir_up;
        sh_periodic <= periodic;
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a queue-based scoreboard on {count,tc,busy,done}.
module tb_counter_sequencer;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset, start, stop, hold, dir_up, periodic;
  logic [W-1:0] load_val, term_val;
  logic [W-1:0] count;
  logic         tc, busy, done;

  logic [W+2:0] exp_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  counter_sequencer #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .dir_up   (dir_up),
    .periodic (periodic),
    .load_val (load_val),
    .term_val (term_val),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic cfg(input logic [W-1:0] lv, input logic [W-1:0] tv,
                     input logic du, input logic pe);
    load_val = lv;
    term_val = tv;
    dir_up   = du;
    periodic = pe;
  endtask

  // Drives one cycle of controls at the falling edge and queues the outputs
  // expected right after the following rising edge.
  task automatic cyc(input logic rs, input logic st, input logic sp, input logic hd,
                     input logic [W-1:0] ec, input logic etc, input logic eb,
                     input logic ed, input string nm);
    @(negedge clock);
    reset = rs;
    start = st;
    stop  = sp;
    hold  = hd;
    exp_q.push_back({ec, etc, eb, ed});
    name_q.push_back(nm);
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W+2:0] e, a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {count, tc, busy, done};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, expected count=%0d tc=%b busy=%b done=%b",
                 nm, a[W+2:3], a[2], a[1], a[0], e[W+2:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
    cfg(4'd0, 4'd0, 1'b0, 1'b0);

    cyc(1, 0, 0, 0, 4'd0, 0, 0, 0, "reset");
    cyc(0, 0, 0, 0, 4'd0, 0, 0, 0, "idle_after_reset");

    // One-shot up 3..6
    cfg(4'd3, 4'd6, 1'b1, 1'b0);
    cyc(0, 1, 0, 0, 4'd3, 0, 1, 0, "t1_start");
    cyc(0, 0, 0, 0, 4'd4, 0, 1, 0, "t1_c4");
    cyc(0, 0, 0, 0, 4'd5, 0, 1, 0, "t1_c5");
    cyc(0, 0, 0, 0, 4'd6, 0, 1, 0, "t1_c6");
    cyc(0, 0, 0, 0, 4'd6, 1, 0, 1, "t1_tc_done");
    cyc(0, 0, 0, 0, 4'd6, 0, 0, 1, "t1_done_hold");
    cyc(0, 0, 0, 0, 4'd6, 0, 0, 1, "t1_done_hold2");

    // Periodic down 2..0
    cfg(4'd2, 4'd0, 1'b0, 1'b1);
    cyc(0, 1, 0, 0, 4'd2, 0, 1, 0, "t2_start");
    cyc(0, 0, 0, 0, 4'd1, 0, 1, 0, "t2_c1");
    cyc(0, 0, 0, 0, 4'd0, 0, 1, 0, "t2_c0");
    cyc(0, 0, 0, 0, 4'd2, 1, 1, 0, "t2_reload1");
    cyc(0, 0, 0, 0, 4'd1, 0, 1, 0, "t2_c1b");
    cyc(0, 0, 0, 0, 4'd0, 0, 1, 0, "t2_c0b");
    cyc(0, 0, 0, 0, 4'd2, 1, 1, 0, "t2_reload2");
    cyc(0, 0, 0, 0, 4'd1, 0, 1, 0, "t2_c1c");

    // One-shot up across the 15->0 wrap
    cfg(4'd14, 4'd1, 1'b1, 1'b0);
    cyc(0, 1, 0, 0, 4'd14, 0, 1, 0, "t3_start");
    cyc(0, 0, 0, 0, 4'd15, 0, 1, 0, "t3_c15");
    cyc(0, 0, 0, 0, 4'd0,  0, 1, 0, "t3_wrap0");
    cyc(0, 0, 0, 0, 4'd1,  0, 1, 0, "t3_c1");
    cyc(0, 0, 0, 0, 4'd1,  1, 0, 1, "t3_tc_done");
    cyc(0, 0, 0, 0, 4'd1,  0, 0, 1, "t3_done_hold");

    // Periodic 0..9 with pause at 4 and mid-run config change
    cfg(4'd0, 4'd9, 1'b1, 1'b1);
    cyc(0, 1, 0, 0, 4'd0, 0, 1, 0, "t4_start");
    cyc(0, 0, 0, 0, 4'd1, 0, 1, 0, "t4_c1");
    cfg(4'd15, 4'd15, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 4'd2, 0, 1, 0, "t4_cfg_ignored");
    cyc(0, 0, 0, 0, 4'd3, 0, 1, 0, "t4_c3");
    cyc(0, 0, 0, 0, 4'd4, 0, 1, 0, "t4_c4");
    cyc(0, 0, 0, 1, 4'd4, 0, 1, 0, "t4_pause1");
    cyc(0, 0, 0, 1, 4'd4, 0, 1, 0, "t4_pause2");
    cyc(0, 0, 0, 1, 4'd4, 0, 1, 0, "t4_pause3");
    cyc(0, 0, 0, 0, 4'd4, 0, 1, 0, "t4_resume_edge");
    cyc(0, 0, 0, 0, 4'd5, 0, 1, 0, "t4_c5");
    cyc(0, 0, 0, 0, 4'd6, 0, 1, 0, "t4_c6");
    cyc(0, 0, 0, 1, 4'd6, 0, 1, 0, "t4_pause_again");
    cyc(0, 0, 1, 1, 4'd0, 0, 0, 0, "t5_stop_in_pause");
    cyc(0, 1, 1, 0, 4'd0, 0, 0, 0, "t5_stop_beats_start");
    cyc(0, 0, 0, 0, 4'd0, 0, 0, 0, "t5_idle_stays");

    // Start+hold: start wins; load==term periodic fires every cycle
    cfg(4'd5, 4'd5, 1'b1, 1'b1);
    cyc(0, 1, 0, 1, 4'd5, 0, 1, 0, "t6_start_over_hold");
    cyc(0, 0, 0, 0, 4'd5, 1, 1, 0, "t6_tc1");
    cyc(0, 0, 0, 0, 4'd5, 1, 1, 0, "t6_tc2");
    cyc(0, 0, 0, 1, 4'd5, 0, 1, 0, "t6_pause_no_tc");

    // Reset mid-run at count 7, then load==term one-shot
    cfg(4'd0, 4'd15, 1'b1, 1'b0);
    cyc(0, 1, 0, 0, 4'd0, 0, 1, 0, "t7_start");
    for (int i = 1; i <= 7; i++) cyc(0, 0, 0, 0, W'(i), 0, 1, 0, "t7_count");
    cyc(1, 0, 0, 0, 4'd0, 0, 0, 0, "t7_reset_mid_run");
    cfg(4'd5, 4'd5, 1'b1, 1'b0);
    cyc(0, 1, 0, 0, 4'd5, 0, 1, 0, "t7_start_eq");
    cyc(0, 0, 0, 0, 4'd5, 1, 0, 1, "t7_tc_done");
    cyc(0, 0, 0, 0, 4'd5, 0, 0, 1, "t7_done_hold");

    @(negedge clock);
    start = 1'b0; stop = 1'b0; hold = 1'b0; reset = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
